// File: rtl/main_memory_responder_if.sv
// Request/handshake bundle between a cache controller (master) and main memory (slave).
// The byte data bus stays a separate inout port on the responder.
interface main_memory_responder_if #(
    parameter int AWIDTH = 16
);
    logic [AWIDTH-1:0] addr_mem;
    logic              read_mem_enable;
    logic              write_mem_enable;
    logic              ready_memory;

    modport master (
        output addr_mem,
        output read_mem_enable,
        output write_mem_enable,
        input  ready_memory
    );

    modport slave (
        input  addr_mem,
        input  read_mem_enable,
        input  write_mem_enable,
        output ready_memory
    );
endinterface

// File: rtl/main_memory_responder.sv
// Byte-serial main-memory responder: block refill reads and write-backs over a shared byte bus.
// Optional MEM_PROTOCOL_CHECK_EN adds a sticky protocol_err output for initiator misuse.
module main_memory_responder #(
    parameter int AWIDTH     = 16,
    parameter int DATAWIDTH  = 8,
    parameter int BLOCKSIZE  = 4,
    parameter int MEM_AWIDTH = 10,
    parameter int ACCESS_LAT = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    main_memory_responder_if.slave  bus,
    inout  wire [DATAWIDTH-1:0]     data_mem
`ifdef MEM_PROTOCOL_CHECK_EN
    ,
    output logic                    protocol_err
`endif
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_WAIT  = 3'd1;
    localparam logic [2:0] RD_BURST = 3'd2;
    localparam logic [2:0] WR_BURST = 3'd3;
    localparam logic [2:0] WR_WAIT  = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    localparam int            BW        = (BLOCKSIZE > 1) ? $clog2(BLOCKSIZE) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCKSIZE - 1);
    // Wait states count down to zero, so the counter is loaded one short of the latency.
    localparam logic [3:0]    LAT_LOAD  = (ACCESS_LAT > 0) ? 4'(ACCESS_LAT - 1) : 4'd0;

    logic [2:0]            state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [3:0]            lat_q, lat_d;
    logic [MEM_AWIDTH-1:0] base_q, base_d;
    logic                  ready_q, ready_d;

    logic [DATAWIDTH-1:0]  mem_q [2**MEM_AWIDTH];

    logic [MEM_AWIDTH-1:0] req_base;
    logic [MEM_AWIDTH-1:0] beat_addr;
    logic                  rd_drive;

    assign req_base  = {bus.addr_mem[MEM_AWIDTH-1:2], 2'b00};
    assign beat_addr = base_q + MEM_AWIDTH'(beat_q);
    assign rd_drive  = (state_q == RD_BURST);

    assign data_mem         = rd_drive ? mem_q[beat_addr] : {DATAWIDTH{1'bz}};
    assign bus.ready_memory = ready_q;

    // Upper address bits alias by design; the low two bits only matter to the protocol checker.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.addr_mem[AWIDTH-1:MEM_AWIDTH], bus.addr_mem[1:0]};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        base_d  = base_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (bus.write_mem_enable) begin
                    base_d  = req_base;
                    beat_d  = '0;
                    ready_d = 1'b0;
                    state_d = WR_BURST;
                end else if (bus.read_mem_enable) begin
                    base_d  = req_base;
                    beat_d  = '0;
                    lat_d   = LAT_LOAD;
                    ready_d = 1'b0;
                    state_d = (ACCESS_LAT > 0) ? RD_WAIT : RD_BURST;
                end
            end
            RD_WAIT: begin
                if (lat_q == 4'd0) state_d = RD_BURST;
                else               lat_d   = lat_q - 1'b1;
            end
            RD_BURST: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = DONE;
            end
            WR_BURST: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    lat_d   = LAT_LOAD;
                    state_d = (ACCESS_LAT > 0) ? WR_WAIT : DONE;
                end
            end
            WR_WAIT: begin
                if (lat_q == 4'd0) state_d = DONE;
                else               lat_d   = lat_q - 1'b1;
            end
            DONE: begin
                beat_d  = '0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            base_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            base_q  <= base_d;
            ready_q <= ready_d;
        end
    end

    // Array contents survive reset; an aborted write-back leaves earlier beats in place.
    always_ff @(posedge clock) begin
        if (state_q == WR_BURST) mem_q[beat_addr] <= data_mem;
    end

`ifdef MEM_PROTOCOL_CHECK_EN
    logic rd_en_prev_q, wr_en_prev_q, perr_q;
    logic perr_set;

    assign perr_set =
        ((state_q == IDLE) && bus.read_mem_enable && bus.write_mem_enable) ||
        (!ready_q && ((bus.read_mem_enable && !rd_en_prev_q) ||
                      (bus.write_mem_enable && !wr_en_prev_q))) ||
        ((state_q == IDLE) && (bus.read_mem_enable || bus.write_mem_enable) &&
         (bus.addr_mem[1:0] != 2'b00));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_en_prev_q <= 1'b0;
            wr_en_prev_q <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            rd_en_prev_q <= bus.read_mem_enable;
            wr_en_prev_q <= bus.write_mem_enable;
            if (perr_set) perr_q <= 1'b1;
        end
    end

    assign protocol_err = perr_q;
`endif
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: one instance at ACCESS_LAT=3, one at ACCESS_LAT=0.
module tb_main_memory_responder;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    main_memory_responder_if #(.AWIDTH(16)) mif_a ();
    main_memory_responder_if #(.AWIDTH(16)) mif_b ();

    wire  [7:0] dq_a;
    wire  [7:0] dq_b;
    logic [7:0] tb_dq;
    logic       tb_drv_a, tb_drv_b;
    assign dq_a = tb_drv_a ? tb_dq : 8'bz;
    assign dq_b = tb_drv_b ? tb_dq : 8'bz;

`ifdef MEM_PROTOCOL_CHECK_EN
    logic perr_a, perr_b;
`endif

    main_memory_responder #(.ACCESS_LAT(3)) u_dut_a (
        .clock        (clock),
        .reset        (reset),
        .bus          (mif_a),
        .data_mem     (dq_a)
`ifdef MEM_PROTOCOL_CHECK_EN
        ,
        .protocol_err (perr_a)
`endif
    );

    main_memory_responder #(.ACCESS_LAT(0)) u_dut_b (
        .clock        (clock),
        .reset        (reset),
        .bus          (mif_b),
        .data_mem     (dq_b)
`ifdef MEM_PROTOCOL_CHECK_EN
        ,
        .protocol_err (perr_b)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input bit u, input logic [15:0] a, input logic rd, input logic wr);
        if (u) begin
            mif_b.addr_mem = a; mif_b.read_mem_enable = rd; mif_b.write_mem_enable = wr;
        end else begin
            mif_a.addr_mem = a; mif_a.read_mem_enable = rd; mif_a.write_mem_enable = wr;
        end
    endtask

    task automatic set_drv(input bit u, input logic en);
        if (u) tb_drv_b = en;
        else   tb_drv_a = en;
    endtask

    function automatic logic get_ready(input bit u);
        return u ? mif_b.ready_memory : mif_a.ready_memory;
    endfunction

    function automatic logic [7:0] get_data(input bit u);
        return u ? dq_b : dq_a;
    endfunction

    function automatic logic get_drv(input bit u);
        return u ? u_dut_b.rd_drive : u_dut_a.rd_drive;
    endfunction

    // line holds beat 0 in bits [7:0]; called with inputs idle, just after a clock edge
    task automatic do_read(input bit u, input logic [15:0] a, input logic [31:0] line,
                           input int lat, input bit pulse, input string tag);
        set_req(u, a, 1'b1, 1'b0);
        step();
        set_req(u, a, 1'b0, 1'b0);
        chk({tag, "_rdy_drop"}, 32'(get_ready(u)), 32'd0);
        for (int i = 0; i < lat; i++) begin
            chk({tag, $sformatf("_wait%0d_idle_bus", i)}, 32'(get_drv(u)), 32'd0);
            step();
        end
        for (int j = 0; j < 4; j++) begin
            chk({tag, $sformatf("_beat%0d", j)}, 32'(get_data(u)), 32'(line[8*j +: 8]));
            if (pulse && j == 1) set_req(u, a, 1'b1, 1'b0);
            step();
            set_req(u, a, 1'b0, 1'b0);
        end
        chk({tag, "_done_busy"}, 32'(get_ready(u)), 32'd0);
        chk({tag, "_done_release"}, 32'(get_drv(u)), 32'd0);
        step();
        chk({tag, "_rdy_back"}, 32'(get_ready(u)), 32'd1);
        if (pulse) begin
            step();
            chk({tag, "_no_requeue_rdy"}, 32'(get_ready(u)), 32'd1);
            chk({tag, "_no_requeue_bus"}, 32'(get_drv(u)), 32'd0);
        end
    endtask

    task automatic do_write(input bit u, input logic [15:0] a, input logic [31:0] line,
                            input int lat, input logic rd, input string tag);
        set_req(u, a, rd, 1'b1);
        step();
        set_req(u, a, 1'b0, 1'b0);
        chk({tag, "_rdy_drop"}, 32'(get_ready(u)), 32'd0);
        for (int j = 0; j < 4; j++) begin
            tb_dq = line[8*j +: 8];
            set_drv(u, 1'b1);
            chk({tag, $sformatf("_beat%0d_no_rd", j)}, 32'(get_drv(u)), 32'd0);
            step();
        end
        set_drv(u, 1'b0);
        for (int i = 0; i < lat; i++) begin
            chk({tag, $sformatf("_wait%0d_busy", i)}, 32'(get_ready(u)), 32'd0);
            step();
        end
        chk({tag, "_done_busy"}, 32'(get_ready(u)), 32'd0);
        step();
        chk({tag, "_rdy_back"}, 32'(get_ready(u)), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        tb_dq    = 8'h00;
        tb_drv_a = 1'b0;
        tb_drv_b = 1'b0;
        set_req(1'b0, 16'h0000, 1'b0, 1'b0);
        set_req(1'b1, 16'h0000, 1'b0, 1'b0);
        repeat (2) step();
        chk("rst_ready_a", 32'(mif_a.ready_memory), 32'd1);
        chk("rst_ready_b", 32'(mif_b.ready_memory), 32'd1);
        chk("rst_bus_a", 32'(u_dut_a.rd_drive), 32'd0);
`ifdef MEM_PROTOCOL_CHECK_EN
        chk("rst_perr_a", 32'(perr_a), 32'd0);
`endif
        reset = 1'b0;
        step();

        // Basic refill with three wait states
        do_write(1'b0, 16'h0040, 32'h44332211, 3, 1'b0, "pre40");
        do_read (1'b0, 16'h0040, 32'h44332211, 3, 1'b0, "rd40");

        // Write-back then read-back of the same line; low address bits are ignored
        do_write(1'b0, 16'h0104, 32'hDDCCBBAA, 3, 1'b0, "wr104");
        do_read (1'b0, 16'h0104, 32'hDDCCBBAA, 3, 1'b0, "rd104");
        chk("mem105", 32'(u_dut_a.mem_q[10'h105]), 32'hBB);
        do_read (1'b0, 16'h0106, 32'hDDCCBBAA, 3, 1'b0, "rd106");

        // Both enables in IDLE: write wins, no read beats
        do_write(1'b0, 16'h0008, 32'h08070605, 3, 1'b1, "both08");
        do_read (1'b0, 16'h0008, 32'h08070605, 3, 1'b0, "rd08");
`ifdef MEM_PROTOCOL_CHECK_EN
        chk("perr_both", 32'(perr_a), 32'd1);
        chk("perr_b_clean", 32'(perr_b), 32'd0);
`endif

        // Zero-latency instance: write via aliased address, read at the top of the array
        do_write(1'b1, 16'h07FC, 32'hC4C3C2C1, 0, 1'b0, "wr7fc");
        do_read (1'b1, 16'h03FC, 32'hC4C3C2C1, 0, 1'b0, "rd3fc");
        chk("alias3ff", 32'(u_dut_b.mem_q[10'h3FF]), 32'hC4);

        // Reset during a write-back after two beats
        do_write(1'b0, 16'h0010, 32'h5D5C5B5A, 3, 1'b0, "pre10");
        set_req(1'b0, 16'h0010, 1'b0, 1'b1);
        step();
        set_req(1'b0, 16'h0010, 1'b0, 1'b0);
        tb_dq = 8'h01; tb_drv_a = 1'b1;
        step();
        tb_dq = 8'h02;
        step();
        tb_dq = 8'h03;
        #1 reset = 1'b1;
        #1;
        chk("abort_ready", 32'(mif_a.ready_memory), 32'd1);
        chk("abort_bus", 32'(u_dut_a.rd_drive), 32'd0);
        tb_drv_a = 1'b0;
        step();
        reset = 1'b0;
        chk("abort_m10", 32'(u_dut_a.mem_q[10'h010]), 32'h01);
        chk("abort_m11", 32'(u_dut_a.mem_q[10'h011]), 32'h02);
        chk("abort_m12", 32'(u_dut_a.mem_q[10'h012]), 32'h5C);
        chk("abort_m13", 32'(u_dut_a.mem_q[10'h013]), 32'h5D);
        step();

        // Read enable pulsed mid-burst is ignored
        do_read(1'b0, 16'h0040, 32'h44332211, 3, 1'b1, "pulse40");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
